// File: rtl/prog_load_if.sv
// Bus bundle between the program-load controller, the I2C programming slave,
// the CPU fetch port and the single-port program memory.
interface prog_load_if #(
  parameter int ADDR_W = 5
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_stop;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_halt;
  logic              busy;
  logic              err;

  modport master (
    output rx_valid, rx_data, rx_stop, cpu_req, cpu_addr,
    input  cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_halt, busy, err
  );

  modport slave (
    input  rx_valid, rx_data, rx_stop, cpu_req, cpu_addr,
    output cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_halt, busy, err
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// Program-load controller: decodes I2C command bytes into WRITE/RUN/HALT,
// loads program memory with auto-incrementing address and arbitrates the port.
module prog_load_ctrl #(
  parameter int          ADDR_W  = 5,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic       clk,
  input logic       rst_n,
  prog_load_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_CMDEND = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam logic [7:0]        CMD_WRITE = 8'hA0;
  localparam logic [7:0]        CMD_RUN   = 8'hA1;
  localparam logic [7:0]        CMD_HALT  = 8'hA2;
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [15:0]       tmo_cnt_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wdata_r;
  logic              wr_cycle_r;
  logic              err_r;
  logic              halt_r;
  logic              pending_run_r;

  logic tmo_hit_s;
  logic addr_hi_bad_s;
  logic cmd_write_s;
  logic cmd_run_s;
  logic cmd_halt_s;
  logic cmd_bad_s;
  logic addr_load_s;
  logic addr_bad_s;
  logic data_wr_s;
  logic extra_byte_s;
  logic run_release_s;
  logic busy_s;

  assign addr_hi_bad_s = ((bus.rx_data >> ADDR_W) != 8'd0);
  assign tmo_hit_s     = (state_r != ST_IDLE) && !bus.rx_valid && !bus.rx_stop &&
                         (tmo_cnt_r == (TIMEOUT - 16'd1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a byte is processed under the current state before a coincident stop
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_WRITE: state_nxt_s = ST_ADDR;
            CMD_RUN:   state_nxt_s = ST_CMDEND;
            CMD_HALT:  state_nxt_s = ST_CMDEND;
            default:   state_nxt_s = ST_DRAIN;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (bus.rx_valid) begin
          state_nxt_s = addr_hi_bad_s ? ST_DRAIN : ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA:   state_nxt_s = ST_DATA;
      ST_CMDEND: begin
        if (bus.rx_valid) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_CMDEND;
        end
      end
      ST_DRAIN:  state_nxt_s = ST_DRAIN;
      default:   state_nxt_s = ST_IDLE;
    endcase
    if (bus.rx_stop || tmo_hit_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Per-state action strobes
  always_comb begin
    cmd_write_s   = 1'b0;
    cmd_run_s     = 1'b0;
    cmd_halt_s    = 1'b0;
    cmd_bad_s     = 1'b0;
    addr_load_s   = 1'b0;
    addr_bad_s    = 1'b0;
    data_wr_s     = 1'b0;
    extra_byte_s  = 1'b0;
    run_release_s = 1'b0;
    busy_s        = (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          cmd_write_s = (bus.rx_data == CMD_WRITE);
          cmd_run_s   = (bus.rx_data == CMD_RUN);
          cmd_halt_s  = (bus.rx_data == CMD_HALT);
          cmd_bad_s   = !(cmd_write_s || cmd_run_s || cmd_halt_s);
        end else begin
          cmd_bad_s = 1'b0;
        end
        // RUN with stop in the same cycle releases the CPU immediately
        run_release_s = cmd_run_s && bus.rx_stop;
      end
      ST_ADDR: begin
        addr_load_s = bus.rx_valid;
        addr_bad_s  = bus.rx_valid && addr_hi_bad_s;
      end
      ST_DATA:   data_wr_s = bus.rx_valid;
      ST_CMDEND: begin
        extra_byte_s  = bus.rx_valid;
        run_release_s = bus.rx_stop && !bus.rx_valid && pending_run_r;
      end
      ST_DRAIN:  busy_s = 1'b1;
      default:   busy_s = 1'b1;
    endcase
  end

  // Idle-cycle watchdog for a stalled transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 16'd0;
    end else if ((state_r == ST_IDLE) || bus.rx_valid || bus.rx_stop || tmo_hit_s) begin
      tmo_cnt_r <= 16'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end
  end

  // Write pointer and registered memory write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      wr_addr_r  <= {ADDR_W{1'b0}};
      wdata_r    <= 8'd0;
      wr_cycle_r <= 1'b0;
    end else begin
      wr_cycle_r <= data_wr_s;
      if (addr_load_s) begin
        wr_ptr_r <= bus.rx_data[ADDR_W-1:0];
      end else if (data_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (data_wr_s) begin
        wr_addr_r <= wr_ptr_r;
        wdata_r   <= bus.rx_data;
      end else begin
        wr_addr_r <= wr_addr_r;
        wdata_r   <= wdata_r;
      end
    end
  end

  // Sticky error, CPU halt and deferred RUN bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r         <= 1'b0;
      halt_r        <= 1'b1;
      pending_run_r <= 1'b0;
    end else begin
      if (cmd_bad_s || addr_bad_s || extra_byte_s || tmo_hit_s) begin
        err_r <= 1'b1;
      end else if (cmd_write_s || cmd_run_s || cmd_halt_s) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
      if (run_release_s) begin
        halt_r <= 1'b0;
      end else if (cmd_write_s || cmd_halt_s) begin
        halt_r <= 1'b1;
      end else begin
        halt_r <= halt_r;
      end
      if ((state_nxt_s == ST_IDLE) || extra_byte_s || tmo_hit_s) begin
        pending_run_r <= 1'b0;
      end else if (cmd_run_s) begin
        pending_run_r <= 1'b1;
      end else begin
        pending_run_r <= pending_run_r;
      end
    end
  end

  assign bus.mem_we    = wr_cycle_r;
  assign bus.cpu_gnt   = bus.cpu_req && !halt_r && !wr_cycle_r;
  assign bus.mem_en    = wr_cycle_r || bus.cpu_gnt;
  assign bus.mem_addr  = wr_cycle_r ? wr_addr_r : bus.cpu_addr;
  assign bus.mem_wdata = wdata_r;
  assign bus.cpu_halt  = halt_r;
  assign bus.busy      = busy_s;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Scoreboard bench for prog_load_ctrl: expected memory writes are queued by the
// stimulus and consumed by a monitor; control outputs are checked inline.
module tb_prog_load_ctrl;
  localparam int          AW  = 5;
  localparam logic [15:0] TMO = 16'd40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_load_if #(.ADDR_W(AW)) bus ();
  prog_load_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", {27'd0, bus.mem_addr}, {27'd0, mon_e.addr});
        check("write_data", {24'd0, bus.mem_wdata}, {24'd0, mon_e.data});
      end
    end
  end

  // Called at a negedge; presents a byte for one cycle and returns at the next negedge
  task automatic drive(input logic [7:0] b, input logic stp);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_stop  = stp;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_stop  = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b, input logic [AW-1:0] a, input logic stp);
    exp_q.push_back('{addr: a, data: b});
    drive(b, stp);
  endtask

  task automatic send_stop();
    bus.rx_stop = 1'b1;
    @(negedge clk);
    bus.rx_stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_stop  = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 5'd9;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_halt",    bus.cpu_halt, 1);
    check("rst_busy",    bus.busy, 0);
    check("rst_err",     bus.err, 0);
    check("rst_we",      bus.mem_we, 0);
    check("rst_en",      bus.mem_en, 0);
    check("rst_gnt",     bus.cpu_gnt, 0);
    check("rst_addr",    {27'd0, bus.mem_addr}, 9);
    check("rst_wdata",   bus.mem_wdata, 0);

    // Write burst, back-to-back bytes
    drive(8'hA0, 1'b0);
    check("wr_halt", bus.cpu_halt, 1);
    check("wr_busy", bus.busy, 1);
    drive(8'h03, 1'b0);
    send_data(8'h11, 5'd3, 1'b0);
    check("wr_gnt0", bus.cpu_gnt, 0);
    send_data(8'h22, 5'd4, 1'b0);
    send_data(8'h33, 5'd5, 1'b0);
    send_stop();
    check("wr_busy_after", bus.busy, 0);
    check("wr_err", bus.err, 0);
    check("wr_gnt1", bus.cpu_gnt, 0);

    // Address wrap
    drive(8'hA0, 1'b0);
    drive(8'h1F, 1'b0);
    send_data(8'hAA, 5'd31, 1'b0);
    send_data(8'hBB, 5'd0, 1'b0);
    send_stop();
    check("wrap_err", bus.err, 0);

    // Run and arbitrate
    bus.cpu_addr = 5'd7;
    drive(8'hA1, 1'b0);
    check("run_halt_before_stop", bus.cpu_halt, 1);
    check("run_gnt_before_stop", bus.cpu_gnt, 0);
    send_stop();
    check("run_halt", bus.cpu_halt, 0);
    check("run_gnt", bus.cpu_gnt, 1);
    check("run_en", bus.mem_en, 1);
    check("run_addr", {27'd0, bus.mem_addr}, 7);
    check("run_we", bus.mem_we, 0);

    // Bad command: everything drained until stop
    drive(8'h55, 1'b0);
    check("bad_err", bus.err, 1);
    check("bad_busy", bus.busy, 1);
    drive(8'hA0, 1'b0);
    drive(8'h01, 1'b0);
    drive(8'h77, 1'b0);
    send_stop();
    check("bad_busy_after", bus.busy, 0);
    check("bad_err_sticky", bus.err, 1);
    check("bad_halt_kept", bus.cpu_halt, 0);
    drive(8'hA2, 1'b0);
    check("halt_clears_err", bus.err, 0);
    check("halt_sets_halt", bus.cpu_halt, 1);
    send_stop();

    // Address out of range
    drive(8'hA0, 1'b0);
    drive(8'h40, 1'b0);
    check("addr_range_err", bus.err, 1);
    drive(8'h12, 1'b0);
    send_stop();
    check("addr_range_busy", bus.busy, 0);

    // Extra byte after RUN cancels it
    drive(8'hA1, 1'b0);
    check("run_clears_err", bus.err, 0);
    drive(8'h00, 1'b0);
    check("extra_err", bus.err, 1);
    send_stop();
    check("extra_halt", bus.cpu_halt, 1);
    check("extra_err_sticky", bus.err, 1);
    drive(8'hA2, 1'b0);
    check("a2_clears_err", bus.err, 0);
    send_stop();

    // Timeout mid-transaction
    drive(8'hA0, 1'b0);
    drive(8'h02, 1'b0);
    repeat (int'(TMO) - 3) @(negedge clk);
    check("tmo_not_early", bus.busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (bus.busy === 1'b1) @(negedge clk);
    end
    check("tmo_busy", bus.busy, 0);
    check("tmo_err", bus.err, 1);
    check("tmo_halt", bus.cpu_halt, 1);

    // Last data byte coincident with stop
    drive(8'hA0, 1'b0);
    drive(8'h04, 1'b0);
    send_data(8'h5A, 5'd4, 1'b1);
    check("coinc_busy", bus.busy, 0);
    check("coinc_err", bus.err, 0);

    // Asynchronous reset while a write pulse is on the bus
    drive(8'hA0, 1'b0);
    drive(8'h08, 1'b0);
    send_data(8'h99, 5'd8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", bus.mem_we, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_halt", bus.cpu_halt, 1);
    check("arst_err", bus.err, 0);
    check("arst_en", bus.mem_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("pending_writes", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
